// File: rtl/param_ram_pkg.sv
// Shared types and default geometry for the parametrised program/data RAM.
package param_ram_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/ram_clear_seq.sv
// Clear-sweep sequencer: walks every address once after reset or a soft clear.
module ram_clear_seq
    import param_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    // One spare counter bit keeps the terminal-count compare free of wrap ambiguity.
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    state_t          state_reg, state_next;
    logic [ADDR_W:0] cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                if (cnt_reg == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy     = (state_reg == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_reg[ADDR_W-1:0];
endmodule

// File: rtl/param_ram.sv
// Single-port synchronous RAM with registered read, selectable read-during-write
// behaviour and a counter-driven clear sweep on reset or soft clear.
module param_ram
    import param_ram_pkg::*;
#(
    parameter int               DATA_W      = DEF_DATA_W,
    parameter int               ADDR_W      = DEF_ADDR_W,
    parameter int               WRITE_FIRST = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] out_reg;
    logic              out_valid_reg;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;

    ram_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A soft clear seen in IDLE pre-empts any access issued in the same cycle.
    assign user_ok   = !busy && !rst && !clear;
    assign mem_we    = clr_we || (user_ok && write);
    assign mem_waddr = clr_we ? clr_addr : address;
    assign mem_wdata = clr_we ? CLEAR_VAL : data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    generate
        if (WRITE_FIRST != 0) begin : g_write_first
            assign rd_word = write ? data : mem[address];
        end else begin : g_read_first
            assign rd_word = mem[address];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (user_ok && read) begin
                out_reg       <= rd_word;
                out_valid_reg <= 1'b1;
            end
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
endmodule
